serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/full_adder.sv | 17 +
 rtl/serial_adder.sv | 108 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and the width helper for serial_adder.
//   state_t : IDLE / RUN / DONE encodings of the serial adder controller
//   clog2   : ceiling log2, never below 1, used to size the bit counter
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell.
//   i_a, i_b : operand bits
//   i_c      : carry in
//   o_s      : sum bit
//   o_c      : carry out
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder (a + b + cin), LSB first, one bit per clock.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   start  : request a new addition, honoured when not busy (IDLE or DONE)
//   a, b   : operands, captured on accepted start
//   cin    : carry in, captured on accepted start
//   busy   : high during the WIDTH RUN cycles
//   done   : one-cycle pulse when sum/cout are valid
//   sum    : result, held until the next addition runs
//   cout   : final carry out, held with sum
//   ovf    : signed overflow, held with sum (only with SERIAL_ADDER_OVF_EN defined)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic             w_load;

    full_adder u_fa (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_co)
    );

    // DONE accepts a new start just like IDLE, giving back-to-back operation
    always_comb begin
        w_last = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
        w_load = start && (r_state != RUN);
        w_next = (r_state == RUN) ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
        busy   = (r_state == RUN);
        done   = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_a     <= {1'b0, r_a[WIDTH-1:1]};
                r_b     <= {1'b0, r_b[WIDTH-1:1]};
                r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                r_carry <= w_co;
                // explicit wrap so non-power-of-two widths also restart at 0
                r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
                if (w_last) r_cout <= w_co;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // in the last RUN cycle r_carry is the carry into the MSB
    always_ff @(posedge clk) begin
        if (!rst_n) r_ovf <= 1'b0;
        else if (w_last && !w_load) r_ovf <= r_carry ^ w_co;
    end

    assign ovf = r_ovf;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
